// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM operand loader and its result collector.
//   DEF_K / DEF_N / DEF_ADDR_W : default word width, words per operand, address width
//   loader_state_t             : loader sequencing states
//   ENA_X / ENA_Y / ENA_M      : bit positions inside wr_ena / in_mask
package iddmm_pkg;

  localparam int DEF_K      = 128;
  localparam int DEF_N      = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_N);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    REQ     = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } loader_state_t;

  localparam int ENA_X = 0;
  localparam int ENA_Y = 1;
  localparam int ENA_M = 2;

endpackage

// File: rtl/iddmm_result_collector.sv
// Gathers the N result words returned by iddmm_top into one K*N-bit bus.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart word counter (loader in REQ)
//   active    : loader in COLLECT; grants and task_end outside it are ignored
//   grant/res : result word strobe and data
//   task_end  : completion indication from iddmm_top
//   res_bus   : collected result, word j at [j*K +: K]
//   last      : this cycle captures word N-1
//   err       : sticky, task_end arrived before all N words were captured
module iddmm_result_collector
  import iddmm_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             active,
  input  logic             grant,
  input  logic [K-1:0]     res,
  input  logic             task_end,
  output logic [K*N-1:0]   res_bus,
  output logic             last,
  output logic             err
);

  logic [ADDR_W-1:0] word_idx;

  assign last = active & grant & (word_idx == ADDR_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
      res_bus  <= '0;
      err      <= 1'b0;
    end else begin
      if (clear) begin
        word_idx <= '0;
      end else if (active && grant) begin
        res_bus[word_idx*K +: K] <= res;
        word_idx                 <= word_idx + ADDR_W'(1);
      end
      // task_end on the very cycle that captures the final word is a normal finish.
      if (active && task_end && !last) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iddmm_operand_loader.sv
// Upstream sequencer for iddmm_top: accepts an operand set, streams it word by
// word into iddmm_top, pulses task_req, then collects the N result words.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : operand-set handshake (ready only when idle)
//   in_mask                  : which operands to write (x, y, m; m1 follows m)
//   in_x/in_y/in_m/in_m1     : operand set, word i at [i*K +: K]
//   wr_ena/wr_addr/wr_*      : registered write port into iddmm_top
//   task_req                 : one-cycle start pulse
//   task_grant/res/end       : result stream from iddmm_top
//   out_valid/out_ready      : result handshake, out_res holds all N words
//   err                      : sticky early-task_end flag
//
// state   | meaning
// IDLE    | ready for a new operand set
// LOAD    | presenting word idx on the write port (N cycles)
// REQ     | task_req pulse, collector counter cleared
// COLLECT | capturing result words on task_grant
// DONE    | result held on out_res until out_ready
module iddmm_operand_loader
  import iddmm_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mask,
  input  logic [K*N-1:0]    in_x,
  input  logic [K*N-1:0]    in_y,
  input  logic [K*N-1:0]    in_m,
  input  logic [K-1:0]      in_m1,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  input  logic              task_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*N-1:0]    out_res,
  output logic              err
);

  loader_state_t     state, state_nxt;
  logic [2:0]        mask_q;
  logic [K*N-1:0]    x_q, y_q, m_q;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              accept, load_last, col_last;

  assign in_ready  = (state == IDLE);
  assign task_req  = (state == REQ);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign load_last = (idx == ADDR_W'(N - 1));
  assign idx_nxt   = idx + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_mask != 3'b000) ? LOAD : REQ;
      LOAD:    if (load_last) state_nxt = REQ;
      REQ:     state_nxt = COLLECT;
      COLLECT: if (col_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word 0 is taken straight from the inputs on the accept edge so the first
  // write appears the cycle after acceptance; later words come from the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= '0;
      idx     <= '0;
      wr_ena  <= '0;
      wr_addr <= '0;
      wr_x    <= '0;
      wr_y    <= '0;
      wr_m    <= '0;
      wr_m1   <= '0;
    end else if (accept) begin
      mask_q <= in_mask;
      x_q    <= in_x;
      y_q    <= in_y;
      m_q    <= in_m;
      idx    <= '0;
      if (in_mask != 3'b000) begin
        wr_ena[ENA_X] <= in_mask[ENA_X];
        wr_ena[ENA_Y] <= in_mask[ENA_Y];
        wr_ena[ENA_M] <= in_mask[ENA_M];
        wr_addr       <= '0;
        wr_x          <= in_x[K-1:0];
        wr_y          <= in_y[K-1:0];
        wr_m          <= in_m[K-1:0];
        wr_m1         <= in_m1;
      end
    end else if (state == LOAD) begin
      if (load_last) begin
        wr_ena <= '0;
        idx    <= '0;
      end else begin
        wr_ena  <= mask_q;
        idx     <= idx_nxt;
        wr_addr <= idx_nxt;
        wr_x    <= x_q[idx_nxt*K +: K];
        wr_y    <= y_q[idx_nxt*K +: K];
        wr_m    <= m_q[idx_nxt*K +: K];
      end
    end
  end

  iddmm_result_collector #(
    .K      (K),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == REQ),
    .active   (state == COLLECT),
    .grant    (task_grant),
    .res      (task_res),
    .task_end (task_end),
    .res_bus  (out_res),
    .last     (col_last),
    .err      (err)
  );

endmodule

// File: tb/tb_iddmm_operand_loader.sv
module tb_iddmm_operand_loader;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_mask = '0;
  logic [K*N-1:0]   in_x = '0, in_y = '0, in_m = '0;
  logic [K-1:0]     in_m1 = '0;
  logic [2:0]       wr_ena;
  logic [AW-1:0]    wr_addr;
  logic [K-1:0]     wr_x, wr_y, wr_m, wr_m1;
  logic             task_req;
  logic             task_grant = 1'b0;
  logic [K-1:0]     task_res = '0;
  logic             task_end = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [K*N-1:0]   out_res;
  logic             err;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int ena_cnt = 0;
  int req_snap, ena_snap;
  logic [K-1:0] x_at5;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (task_req) req_cnt++;
    if (wr_ena != 3'b000) ena_cnt++;
  end

  iddmm_operand_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_m       (in_m),
    .in_m1      (in_m1),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_m       (wr_m),
    .wr_m1      (wr_m1),
    .task_req   (task_req),
    .task_grant (task_grant),
    .task_res   (task_res),
    .task_end   (task_end),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .err        (err)
  );

  function automatic logic [K-1:0] word_of(input logic [31:0] tag, input int job, input int i);
    logic [31:0] t;
    t = tag + 32'(job << 16) + 32'(i);
    return {4{t}};
  endfunction

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int job);
    for (int i = 0; i < N; i++) begin
      in_x[i*K +: K] = word_of(32'hA000_0000, job, i);
      in_y[i*K +: K] = word_of(32'hB000_0000, job, i);
      in_m[i*K +: K] = word_of(32'hC000_0000, job, i);
    end
  endtask

  // Accept a set, check the write stream and the single task_req pulse.
  task automatic load_job(input logic [2:0] mask, input logic [K-1:0] m1, input int job);
    chk("in_ready_idle", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_mask  = mask;
    in_m1    = m1;
    tick();
    in_valid = 1'b0;
    if (mask != 3'b000) begin
      for (int i = 0; i < N; i++) begin
        chk("wr_ena", 128'(wr_ena), 128'(mask));
        chk("wr_addr", 128'(wr_addr), 128'(i));
        chk("wr_x", wr_x, word_of(32'hA000_0000, job, i));
        chk("wr_y", wr_y, word_of(32'hB000_0000, job, i));
        chk("wr_m", wr_m, word_of(32'hC000_0000, job, i));
        chk("wr_m1", wr_m1, m1);
        chk("req_in_load", 128'(task_req), 128'(0));
        chk("in_ready_load", 128'(in_ready), 128'(0));
        if (i == 5) x_at5 = wr_x;
        tick();
      end
    end
    chk("task_req_pulse", 128'(task_req), 128'(1));
    chk("wr_ena_off", 128'(wr_ena), 128'(0));
    tick();
    chk("task_req_low", 128'(task_req), 128'(0));
  endtask

  // end_mode: 0 none, 1 task_end with final grant, 2 task_end alone after 20 grants
  task automatic collect(input int gap, input logic [K-1:0] base, input int end_mode);
    for (int j = 0; j < N; j++) begin
      task_grant = 1'b1;
      task_res   = base + 128'(j + 1);
      task_end   = (end_mode == 1 && j == N - 1);
      tick();
      task_grant = 1'b0;
      task_end   = 1'b0;
      task_res   = ~task_res;
      if (end_mode == 2 && j == 19) begin
        task_end = 1'b1;
        tick();
        task_end = 1'b0;
        chk("err_set", 128'(err), 128'(1));
      end
      if (j < N - 1) begin
        chk("out_valid_early", 128'(out_valid), 128'(0));
        repeat (gap) tick();
      end
    end
    chk("out_valid", 128'(out_valid), 128'(1));
    chk("in_ready_done", 128'(in_ready), 128'(0));
  endtask

  task automatic check_res(input logic [K-1:0] base);
    for (int j = 0; j < N; j++) begin
      chk("out_res", out_res[j*K +: K], base + 128'(j + 1));
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    chk("in_ready_before_ack", 128'(in_ready), 128'(0));
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_ack", 128'(in_ready), 128'(1));
    chk("out_valid_after_ack", 128'(out_valid), 128'(0));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_wr_ena", 128'(wr_ena), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_task_req", 128'(task_req), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_out_res0", out_res[K-1:0], 128'(0));
    rst = 1'b0;
    tick();

    // full load, contiguous grants
    set_ops(0);
    req_snap = req_cnt;
    ena_snap = ena_cnt;
    load_job(3'b111, 128'hecd18b11b6a41b9bb3ef4fcae3ba221f, 0);
    chk("x_addr5", x_at5, 128'hA0000005A0000005A0000005A0000005);
    chk("req_count_1", 128'(req_cnt - req_snap), 128'(1));
    chk("ena_count_1", 128'(ena_cnt - ena_snap), 128'(32));
    collect(0, 128'h0, 0);
    chk("err_clean_1", 128'(err), 128'(0));
    check_res(128'h0);
    release_result();

    // partial mask, gapped grants, consumer stalls with stray grants in DONE
    set_ops(1);
    load_job(3'b101, 128'h0123456789abcdef_fedcba9876543210, 1);
    collect(2, 128'h1000, 0);
    for (int c = 0; c < 10; c++) begin
      task_grant = 1'b1;
      task_res   = 128'hbad0_bad0;
      tick();
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    task_grant = 1'b0;
    check_res(128'h1000);
    release_result();

    // zero mask: no writes, task_end with final grant is not an error
    req_snap = req_cnt;
    ena_snap = ena_cnt;
    load_job(3'b000, 128'h5, 2);
    collect(0, 128'h2000, 1);
    chk("err_end_on_last", 128'(err), 128'(0));
    check_res(128'h2000);
    release_result();
    chk("ena_count_mask0", 128'(ena_cnt - ena_snap), 128'(0));
    chk("req_count_mask0", 128'(req_cnt - req_snap), 128'(1));

    // early task_end after 20 grants
    set_ops(2);
    load_job(3'b010, 128'h77, 2);
    collect(0, 128'h3000, 2);
    chk("err_sticky_done", 128'(err), 128'(1));
    check_res(128'h3000);
    release_result();
    chk("err_sticky_idle", 128'(err), 128'(1));

    // reset in the middle of LOAD
    set_ops(3);
    req_snap = req_cnt;
    in_valid = 1'b1;
    in_mask  = 3'b111;
    in_m1    = 128'h99;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("midload_addr", 128'(wr_addr), 128'(10));
    chk("midload_ena", 128'(wr_ena), 128'(7));
    rst = 1'b1;
    #1;
    chk("rst_async_ena", 128'(wr_ena), 128'(0));
    chk("rst_async_ready", 128'(in_ready), 128'(1));
    chk("rst_clears_err", 128'(err), 128'(0));
    chk("rst_clears_res", out_res[K-1:0], 128'(0));
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("no_req_after_rst", 128'(req_cnt - req_snap), 128'(0));
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    // fresh job after the abandoned one
    set_ops(4);
    load_job(3'b011, 128'hcafe, 4);
    collect(1, 128'h4000, 0);
    chk("err_clean_6", 128'(err), 128'(0));
    check_res(128'h4000);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
